// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU bus memory slave.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ROM  = 2'b01;
    localparam logic [1:0] ERR_COLL = 2'b10;

    localparam int unsigned CNT_W = 32;

    // Inclusive address window test, done at 32 bits so full-range bounds stay meaningful.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/cpu_mem_array.sv
// Single-port storage: synchronous write, registered read that holds between read enables.
module cpu_mem_array
    import cpu_mem_pkg::*;
#(
    parameter int unsigned         ADDR_W = 16,
    parameter int unsigned         DATA_W = 8,
    parameter logic [DATA_W-1:0]   FILL   = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Power-up fill; the array itself is never reset.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: FILL};
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_memory.sv
// MC6809/HD6309 bus memory slave: wait-state FSM, ROM write protection, errors, counters.
module cpu_bus_memory
    import cpu_mem_pkg::*;
#(
    parameter int unsigned         ADDR_W      = 16,
    parameter int unsigned         DATA_W      = 8,
    parameter int unsigned         WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0]   ROM_BASE    = 16'hFFF0,
    parameter logic [ADDR_W-1:0]   ROM_LAST    = 16'hFFFF,
    parameter logic [DATA_W-1:0]   FILL        = 8'hA5
) (
    input  logic              cpu_clk,
    input  logic              cpu_reset,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic              bus_oe_i,
    input  logic              bus_we_i,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_ready_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    input  logic              clr_count_i,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic              latch;
    logic              commit;

    logic              req;
    logic              coll;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_wr;
    logic              in_rom;
    logic              mem_we;
    logic              mem_re;
    logic              rom_err;

    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    assign req  = bus_oe_i ^ bus_we_i;
    assign coll = bus_oe_i & bus_we_i;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    latch  = 1'b1;
                    wcnt_d = WS;
                    if (WS == 4'd0) begin
                        state_d = StDone;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    state_d = StDone;
                    commit  = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A zero-wait access commits on its accept edge, so it uses the live bus, not the latches.
    assign acc_addr = (state_q == StIdle) ? bus_addr_i : addr_q;
    assign acc_data = (state_q == StIdle) ? bus_data_i : data_q;
    assign acc_wr   = (state_q == StIdle) ? bus_we_i   : wr_q;

    assign in_rom  = in_window(32'(acc_addr), 32'(ROM_BASE), 32'(ROM_LAST));
    assign mem_we  = commit & acc_wr & ~in_rom;
    assign mem_re  = commit & ~acc_wr;
    assign rom_err = commit & acc_wr & in_rom;

    always_comb begin
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if ((state_q == StIdle) && coll) begin
            err_d      = 1'b1;
            err_code_d = ERR_COLL;
        end
        if (rom_err) begin
            err_d      = 1'b1;
            err_code_d = ERR_ROM;
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (clr_count_i) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else begin
            if (mem_re && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (mem_we && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q    <= StIdle;
            wcnt_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            if (latch) begin
                addr_q <= bus_addr_i;
                data_q <= bus_data_i;
                wr_q   <= bus_we_i;
            end
        end
    end

    cpu_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .FILL   (FILL)
    ) u_array (
        .clk_i   (cpu_clk),
        .rst_i   (cpu_reset),
        .addr_i  (acc_addr),
        .we_i    (mem_we),
        .wdata_i (acc_data),
        .re_i    (mem_re),
        .rdata_o (bus_data_o)
    );

    assign bus_ready_o = (state_q == StDone);
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign rd_count_o  = rd_cnt_q;
    assign wr_count_o  = wr_cnt_q;

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Bench for cpu_bus_memory: three instances (0, 3 and 5 wait states) against a word-level model.
module tb_cpu_bus_memory;

    localparam int WS [3] = '{0, 3, 5};

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        oe    [3];
    logic        we    [3];
    logic        clr   [3];
    logic [15:0] addr  [3];
    logic [7:0]  wdata [3];
    logic [7:0]  rdata [3];
    logic        ready [3];
    logic        err   [3];
    logic [1:0]  code  [3];
    logic [31:0] rdc   [3];
    logic [31:0] wrc   [3];

    // Reference model: sparse memory keyed by instance and address, plus expected outputs.
    logic [7:0]  mem_m [int];
    int unsigned exp_rd   [3];
    int unsigned exp_wr   [3];
    logic [1:0]  exp_code [3];
    logic [7:0]  exp_data [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cpu_bus_memory #(
            .WAIT_STATES (WS[g])
        ) u_dut (
            .cpu_clk     (clk),
            .cpu_reset   (rst[g]),
            .bus_addr_i  (addr[g]),
            .bus_oe_i    (oe[g]),
            .bus_we_i    (we[g]),
            .bus_data_i  (wdata[g]),
            .bus_data_o  (rdata[g]),
            .bus_ready_o (ready[g]),
            .err_o       (err[g]),
            .err_code_o  (code[g]),
            .clr_count_i (clr[g]),
            .rd_count_o  (rdc[g]),
            .wr_count_o  (wrc[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input int k, input string tag);
        check({tag, "_rdata"}, 32'(rdata[k]), 32'(exp_data[k]));
        check({tag, "_code"}, 32'(code[k]), 32'(exp_code[k]));
        check({tag, "_rdcnt"}, rdc[k], exp_rd[k]);
        check({tag, "_wrcnt"}, wrc[k], exp_wr[k]);
    endtask

    task automatic access(input int k, input bit wr, input logic [15:0] a, input logic [7:0] d);
        int lat;
        int key;
        bit rom;
        rom = (a >= 16'hFFF0);
        key = k * 65536 + int'(a);
        @(negedge clk);
        oe[k] = !wr; we[k] = wr; addr[k] = a; wdata[k] = d;
        @(posedge clk); #1;
        // Scramble the bus after acceptance; the access must use the captured values.
        oe[k] = 1'b0; we[k] = 1'b0; addr[k] = 16'($urandom); wdata[k] = 8'($urandom);
        lat = 1;
        while (ready[k] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (wr && rom) begin
            exp_code[k] = 2'b01;
        end else if (wr) begin
            mem_m[key] = d;
            exp_wr[k]++;
        end else begin
            exp_data[k] = mem_m.exists(key) ? mem_m[key] : 8'hA5;
            exp_rd[k]++;
        end
        check("latency", 32'(lat), 32'(WS[k] + 1));
        check("ready", 32'(ready[k]), 32'd1);
        check("err_with_ready", 32'(err[k]), 32'(wr && rom));
        check_state(k, "acc");
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(ready[k]), 32'd0);
        check("err_one_cycle", 32'(err[k]), 32'd0);
    endtask

    task automatic collide(input int k);
        @(negedge clk);
        oe[k] = 1'b1; we[k] = 1'b1; addr[k] = 16'($urandom); wdata[k] = 8'($urandom);
        @(posedge clk); #1;
        oe[k] = 1'b0; we[k] = 1'b0;
        exp_code[k] = 2'b10;
        check("coll_err", 32'(err[k]), 32'd1);
        check("coll_noready", 32'(ready[k]), 32'd0);
        check_state(k, "coll");
        @(posedge clk); #1;
        check("coll_err_drop", 32'(err[k]), 32'd0);
        check("coll_noready2", 32'(ready[k]), 32'd0);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 16'hFFF0 + 16'($urandom_range(0, 15));
        return 16'h1000 + 16'($urandom_range(0, 31));
    endfunction

    initial begin
        int hits;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; oe[k] = 1'b0; we[k] = 1'b0; clr[k] = 1'b0;
            addr[k] = '0; wdata[k] = '0;
            exp_rd[k] = 0; exp_wr[k] = 0; exp_code[k] = 2'b00; exp_data[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(ready[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
            check_state(k, "rst");
        end

        // Directed plan: write/read at zero waits, untouched read at three waits, ROM write.
        access(0, 1'b1, 16'h1000, 8'h3F);
        access(0, 1'b0, 16'h1000, 8'h00);
        check("tp_rd_3f", 32'(rdata[0]), 32'h3F);
        access(1, 1'b0, 16'h2000, 8'h00);
        check("tp_rd_fill", 32'(rdata[1]), 32'hA5);
        access(0, 1'b1, 16'hFFFE, 8'h55);
        access(0, 1'b0, 16'hFFFE, 8'h00);
        check("tp_rom_kept", 32'(rdata[0]), 32'hA5);
        collide(0);

        // Held oe: back-to-back reads every two cycles, clear coinciding with the third commit.
        @(negedge clk);
        oe[0] = 1'b1; addr[0] = 16'h1000;
        exp_data[0] = mem_m.exists(16'h1000) ? mem_m[16'h1000] : 8'hA5;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) clr[0] = 1'b1;
            @(posedge clk); #1;
            if (i == 2) begin
                oe[0] = 1'b0; clr[0] = 1'b0;
                exp_rd[0] = 0; exp_wr[0] = 0;
            end else begin
                exp_rd[0]++;
            end
            check("b2b_ready", 32'(ready[0]), 32'd1);
            check_state(0, "b2b");
            @(posedge clk); #1;
            check("b2b_gap", 32'(ready[0]), 32'd0);
        end
        @(posedge clk); #1;
        check("b2b_stop", 32'(ready[0]), 32'd0);

        // Randomized traffic on every instance.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 9) == 0) collide(k);
                else access(k, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            end
        end

        // Reset during the wait phase of a write discards it and issues no ready.
        @(negedge clk);
        we[2] = 1'b1; addr[2] = 16'h0010; wdata[2] = 8'h77;
        @(posedge clk); #1;
        we[2] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst[2] = 1'b1;
        exp_rd[2] = 0; exp_wr[2] = 0; exp_code[2] = 2'b00; exp_data[2] = 8'h00;
        #1;
        check("mid_rst_ready", 32'(ready[2]), 32'd0);
        check("mid_rst_err", 32'(err[2]), 32'd0);
        check_state(2, "mid_rst");
        @(posedge clk); #1;
        check("mid_rst_ready2", 32'(ready[2]), 32'd0);
        check_state(2, "mid_rst2");
        @(negedge clk);
        rst[2] = 1'b0;
        hits = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready[2] === 1'b1) hits++;
        end
        check("no_ready_after_rst", 32'(hits), 32'd0);
        access(2, 1'b0, 16'h0010, 8'h00);
        check("rst_write_dropped", 32'(rdata[2]), 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
